// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencing-FSM state encoding and the default datapath
// width used by both the adder and the subtractor datapaths.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full-subtractor cell, d = x - y - bin, written as a gate netlist so it
// mirrors the full-adder cell used by the ripple-carry adder.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_xy_x;
    logic w_not_x;
    logic w_not_xy;
    logic w_gen;
    logic w_prop;

    assign w_xy_x   = x ^ y;
    assign w_not_x  = ~x;
    assign w_not_xy = ~w_xy_x;
    // A borrow is generated by 0-1, or propagated when x==y and a borrow comes in.
    assign w_gen    = w_not_x & y;
    assign w_prop   = w_not_xy & bin;
    assign d        = w_xy_x ^ bin;
    assign bout     = w_gen | w_prop;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flip-flop, with start/done handshake.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             overflow
);

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic             r_a_msb;
    logic             r_b_msb;

    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_res_nxt;

    full_subtractor u_cell (
        .x    (r_sa[0]),
        .y    (r_sb[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_accept  = start && (r_state == IDLE || r_state == DONE);
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? RUN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa       <= '0;
            r_sb       <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_borrow   <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
        end else if (w_accept) begin
            r_sa       <= a;
            r_sb       <= b;
            r_res      <= '0;
            r_cnt      <= '0;
            r_borrow   <= 1'b0;
            r_a_msb    <= a[WIDTH-1];
            r_b_msb    <= b[WIDTH-1];
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
        end else if (r_state == RUN) begin
            r_sa     <= r_sa >> 1;
            r_sb     <= r_sb >> 1;
            r_res    <= w_res_nxt;
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + CNT_W'(1);
            // Flags are published from the final bit directly, so they land with done.
            if (w_last) begin
                diff       <= w_res_nxt;
                borrow_out <= w_bout;
                zero       <= (w_res_nxt == '0);
                overflow   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): vector table plus hand-written
// sequences for ignored start, back-to-back operation and mid-run reset.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         zero;
    logic         overflow;

    int unsigned n_checks;
    int unsigned n_errors;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         bo;
        logic         z;
        logic         ov;
    } vec_t;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string name, input vec_t v);
        chk({name, " done"}, 32'(done), 32'd1);
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " diff"}, 32'(diff), 32'(v.diff));
        chk({name, " borrow"}, 32'(borrow_out), 32'(v.bo));
        chk({name, " zero"}, 32'(zero), 32'(v.z));
        chk({name, " ovf"}, 32'(overflow), 32'(v.ov));
    endtask

    // Accept one operation from IDLE, scramble operands during RUN, check timing and result.
    task automatic do_op(input string name, input vec_t v);
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        chk({name, " busy0"}, 32'(busy), 32'd1);
        chk({name, " clr"}, 32'(diff), 32'd0);
        for (int unsigned i = 1; i < W; i++) begin
            tick();
            chk({name, " busyN"}, 32'({busy, done}), 32'b10);
        end
        tick();
        chk_result(name, v);
        tick();
        chk({name, " idle"}, 32'({busy, done}), 32'b00);
        chk({name, " hold"}, 32'({diff, borrow_out, zero, overflow}),
            32'({v.diff, v.bo, v.z, v.ov}));
    endtask

    vec_t vecs[9];

    initial begin
        vec_t v;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        //              a        b        diff     bo    z     ov
        vecs[0] = '{4'b1001, 4'b0101, 4'b0100, 1'b0, 1'b0, 1'b1}; // -7-5 overflows
        vecs[1] = '{4'b0101, 4'b1001, 4'b1100, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{4'b0111, 4'b0111, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{4'b0011, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{4'b0110, 4'b1110, 4'b1000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{4'b1100, 4'b0011, 4'b1001, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{4'b0000, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1};

        tick();
        tick();
        chk("reset", 32'({busy, done, diff, borrow_out, zero, overflow}), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle", 32'({busy, done, diff, borrow_out, zero, overflow}), 32'd0);

        for (int unsigned i = 0; i < 9; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        // start raised mid-RUN must be ignored
        v = '{4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b1};
        start = 1'b1; a = v.a; b = v.b;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; a = 4'b1111; b = 4'b0000;
        tick();
        chk("ign busy", 32'({busy, done}), 32'b10);
        tick();
        start = 1'b0;
        chk_result("ign", v);
        tick();
        chk("ign idle", 32'({busy, done}), 32'b00);

        // start held high: one result per W+1 cycles
        v = '{4'b0011, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0};
        start = 1'b1; a = v.a; b = v.b;
        tick();
        for (int unsigned c = 0; c < 3 * (W + 1); c++) begin
            if (c % (W + 1) == W) begin
                chk_result("b2b", v);
            end else begin
                chk("b2b run", 32'({busy, done}), 32'b10);
            end
            if (c != 3 * (W + 1) - 1) tick();
        end
        start = 1'b0;
        tick();
        chk("b2b stop", 32'({busy, done}), 32'b00);

        // reset during RUN after a borrow has been generated
        start = 1'b1; a = 4'b0000; b = 4'b0001;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort", 32'({busy, done, diff, borrow_out, zero, overflow}), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("abort idle", 32'({busy, done}), 32'b00);
        do_op("post", '{4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
